// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV64 5-stage core: widths, the MEM-stage
// FSM encoding and the EX/MEM and MEM/WB register bundles.
package pipeline_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

  // EX/MEM register contents as produced by ex_stage.
  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd;
    logic             memwrite;
    logic             memread;
    logic             memtoreg;
    logic             regwrite;
    logic             overflow;
  } ex_mem_t;

  // MEM/WB register contents as consumed by wb_stage.
  typedef struct packed {
    logic [XLEN-1:0]  mem_data;
    logic [XLEN-1:0]  alu_result;
    logic [REG_W-1:0] rd;
    logic             memtoreg;
    logic             regwrite;
    logic             err;
    logic             trap;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, stall feedback and MEM/WB outputs of the MEM stage.
// master: upstream / writeback side; slave: mem_stage itself.
interface mem_stage_if;
  import pipeline_pkg::*;

  logic [XLEN-1:0]  ex_mem_alu_result;
  logic [XLEN-1:0]  ex_mem_store_data;
  logic [REG_W-1:0] ex_mem_rd;
  logic             ex_mem_Memwrite;
  logic             ex_mem_Memread;
  logic             ex_mem_MemtoReg;
  logic             ex_mem_Regwrite;
  logic             ex_mem_overflow;

  logic             mem_stall;

  logic [XLEN-1:0]  mem_wb_mem_data;
  logic [XLEN-1:0]  mem_wb_alu_result;
  logic [REG_W-1:0] mem_wb_rd;
  logic             mem_wb_MemtoReg;
  logic             mem_wb_Regwrite;
  logic             mem_wb_err;
  logic             mem_wb_trap;

  modport master (
    output ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_Memwrite,
           ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
    input  mem_stall,
    input  mem_wb_mem_data, mem_wb_alu_result, mem_wb_rd, mem_wb_MemtoReg,
           mem_wb_Regwrite, mem_wb_err, mem_wb_trap
  );

  modport slave (
    input  ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_Memwrite,
           ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
    output mem_stall,
    output mem_wb_mem_data, mem_wb_alu_result, mem_wb_rd, mem_wb_MemtoReg,
           mem_wb_Regwrite, mem_wb_err, mem_wb_trap
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: DEPTH x 64 bits, synchronous write,
// combinational read on the same address.
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];

  // Store port: write the addressed word on the clock edge.
  // NOTE: the array has no reset; clearing it would turn a RAM into
  // DEPTH*64 flops, and software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV64 pipeline: doubleword loads/stores against data_mem,
// multi-cycle load FSM with upstream stall, error qualification and the
// MEM/WB register. Define MEM_OVERFLOW_TRAP_EN to turn ALU overflow on
// non-memory ops into a trap that suppresses register writeback.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  localparam int                AW       = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam bit                MULTI    = (LOAD_LAT > 1);

  ex_mem_t          ex;
  mem_wb_t          entry_d;
  mem_wb_t          mem_wb_q;
  mem_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    word_idx;
  logic [63:0]      rdata;
  logic             misaligned, illegal, acc_err, is_load, is_store;
  logic             stall;

  assign ex = '{alu_result: bus.ex_mem_alu_result,
                store_data: bus.ex_mem_store_data,
                rd:         bus.ex_mem_rd,
                memwrite:   bus.ex_mem_Memwrite,
                memread:    bus.ex_mem_Memread,
                memtoreg:   bus.ex_mem_MemtoReg,
                regwrite:   bus.ex_mem_Regwrite,
                overflow:   bus.ex_mem_overflow};

  // Upper address bits are dropped so accesses wrap modulo DEPTH*8 bytes.
  assign word_idx   = ex.alu_result[AW+2:3];
  assign misaligned = (ex.alu_result[2:0] != 3'b000);
  assign illegal    = ex.memread & ex.memwrite;
  assign acc_err    = (ex.memread | ex.memwrite) & (misaligned | illegal);
  assign is_load    = ex.memread  & ~ex.memwrite & ~misaligned;
  assign is_store   = ex.memwrite & ~ex.memread  & ~misaligned;

  data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk   (clk),
    .we    (is_store),
    .addr  (word_idx),
    .wdata (ex.store_data),
    .rdata (rdata)
  );

`ifndef MEM_OVERFLOW_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = ex.overflow;
`endif

  // MEM/WB entry for the op currently in EX/MEM when it is allowed to retire.
  always_comb begin
    // NOTE: every field gets a value up front so no path leaves one
    // unassigned and infers a latch.
    entry_d            = MEM_WB_BUBBLE;
    entry_d.alu_result = ex.alu_result;
    entry_d.rd         = ex.rd;
    entry_d.memtoreg   = ex.memtoreg;
    entry_d.regwrite   = ex.regwrite;
    if (acc_err) begin
      entry_d.regwrite = 1'b0;
      entry_d.err      = 1'b1;
    end else if (is_load) begin
      entry_d.mem_data = rdata;
    end
`ifdef MEM_OVERFLOW_TRAP_EN
    else if (!ex.memread && !ex.memwrite && ex.overflow) begin
      entry_d.regwrite = 1'b0;
      entry_d.trap     = 1'b1;
    end
`endif
  end

  // Stall: a fresh load in IDLE, or WAIT with more than one cycle left.
  // Reset forces it low so a load still on the inputs cannot hold it high.
  always_comb begin
    stall = 1'b0;
    if (MULTI && rst_n) begin
      unique case (state_q)
        MEM_IDLE: stall = is_load;
        MEM_WAIT: stall = (cnt_q > CNT_ONE);
        default:  stall = 1'b0;
      endcase
    end
  end

  assign bus.mem_stall = stall;

  // Load FSM, latency counter and MEM/WB register.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
      mem_wb_q <= MEM_WB_BUBBLE;
    end else begin
      unique case (state_q)
        MEM_IDLE: begin
          if (MULTI && is_load) begin
            state_q  <= MEM_WAIT;
            cnt_q    <= CNT_INIT;
            mem_wb_q <= MEM_WB_BUBBLE;
          end else begin
            mem_wb_q <= entry_d;
          end
        end
        MEM_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q  <= MEM_IDLE;
            cnt_q    <= '0;
            mem_wb_q <= entry_d;
          end else begin
            cnt_q    <= cnt_q - CNT_ONE;
            mem_wb_q <= MEM_WB_BUBBLE;
          end
        end
        default: begin
          state_q  <= MEM_IDLE;
          cnt_q    <= '0;
          mem_wb_q <= MEM_WB_BUBBLE;
        end
      endcase
    end
  end

  assign bus.mem_wb_mem_data   = mem_wb_q.mem_data;
  assign bus.mem_wb_alu_result = mem_wb_q.alu_result;
  assign bus.mem_wb_rd         = mem_wb_q.rd;
  assign bus.mem_wb_MemtoReg   = mem_wb_q.memtoreg;
  assign bus.mem_wb_Regwrite   = mem_wb_q.regwrite;
  assign bus.mem_wb_err        = mem_wb_q.err;
  assign bus.mem_wb_trap       = mem_wb_q.trap;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV64 pipeline; consumes the EX/MEM register driven by ex_stage and produces the MEM/WB register for writeback.
- Holds a word-addressed data memory; performs doubleword loads and stores.
- Multi-cycle load latency, with a stall output back to IF/ID/EX.
- Sits between ex_stage and the writeback mux.

Parameters:
- DEPTH, 256, number of 64-bit words in data memory (power of 2).
- LOAD_LAT, 2, load latency in cycles (>=1); a load stalls upstream for LOAD_LAT-1 cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_mem_alu_result  in  64  byte address for memory ops; passthrough result otherwise
- ex_mem_store_data  in  64  rs2 value for stores
- ex_mem_rd  in  5  destination register
- ex_mem_Memwrite  in  1  store request
- ex_mem_Memread  in  1  load request
- ex_mem_MemtoReg  in  1  writeback selects memory data
- ex_mem_Regwrite  in  1  writeback enable
- ex_mem_overflow  in  1  ALU signed overflow flag
- mem_stall  out  1  hold upstream stages and EX/MEM contents
- mem_wb_mem_data  out  64  loaded doubleword
- mem_wb_alu_result  out  64  registered ALU result
- mem_wb_rd  out  5  registered rd
- mem_wb_MemtoReg  out  1  registered MemtoReg
- mem_wb_Regwrite  out  1  registered Regwrite (qualified)
- mem_wb_err  out  1  access error on this MEM/WB entry
- mem_wb_trap  out  1  overflow trap (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - All mem_wb_* outputs go to 0 and mem_stall=0.
  - FSM goes to IDLE and the latency counter clears.
  - Memory array is not reset.
- Addressing:
  - Word index = alu_result[$clog2(DEPTH)+2:3]; upper bits are ignored, so addresses wrap modulo DEPTH*8.
  - Misaligned = alu_result[2:0]!=0.
- Illegal request: Memread and Memwrite both 1.
- Error access (misaligned or illegal):
  - No memory write.
  - mem_wb_mem_data=0, mem_wb_Regwrite=0, mem_wb_err=1 for one MEM/WB entry.
  - No stall.
- Non-memory op: MEM/WB captures alu_result, rd, MemtoReg, Regwrite, with mem_wb_mem_data=0 and err=0, on the next edge (latency 1).
- Store:
  - Memory word written with store_data on the next edge.
  - MEM/WB entry captured as for a non-memory op. Stores never stall.
- Load, LOAD_LAT=1: combinational read; mem_wb_mem_data updated on the next edge; no stall.
- Load, LOAD_LAT>1: FSM states IDLE and WAIT.
  - IDLE with a valid load:
    - mem_stall=1 combinationally.
    - Next edge: go to WAIT with cnt=LOAD_LAT-1; MEM/WB captures a bubble (all mem_wb_* = 0).
  - WAIT:
    - mem_stall = (cnt>1); cnt decrements each edge.
    - When cnt==1: mem_stall=0; next edge captures memory data and the ex_mem_* fields into MEM/WB, then returns to IDLE.
  - Upstream must hold ex_mem_* constant while mem_stall=1.
  - Net effect: the load result appears LOAD_LAT edges after first presentation.
- Back-to-back loads: the second load presented in the cycle right after completion starts a fresh IDLE->WAIT sequence.
- Store to word W followed by a load from W: the load returns the new data.
- Reset asserted in WAIT: the pending load is dropped, stall deasserts immediately, FSM goes to IDLE.
- rd=0 with Regwrite: passed through unchanged; the regfile ignores x0.

Optional Feature:
- Macro: MEM_OVERFLOW_TRAP_EN.
- Defined: ex_mem_overflow=1 on a non-memory op forces mem_wb_Regwrite=0 and mem_wb_trap=1 for that entry. The overflow flag is ignored on loads and stores.
- Undefined: the overflow flag is ignored and mem_wb_trap is tied to 0.

Decomposition:
- Package pipeline_pkg:
  - XLEN=64, REG_W=5.
  - mem_state_t enum {MEM_IDLE, MEM_WAIT}.
  - EX/MEM and MEM/WB bundle typedefs, reused by ex_stage and wb_stage.
- Sub-module data_mem: DEPTH x 64 array, synchronous write, combinational read. Instantiated once.
- mem_stage keeps the FSM, the counter, error qualification and the MEM/WB register.

Test Plan:
- Reset mid-operation: load to 0x10 presented, rst_n low while in WAIT -> all mem_wb_*=0 and mem_stall=0 immediately; after release, the load re-presented completes normally.
- Store then load: store 0xDEADBEEF_CAFEF00D to address 0x18, then load 0x18 with rd=5 (LOAD_LAT=2):
  - mem_stall high for 1 cycle with a bubble in MEM/WB.
  - Next entry: mem_wb_mem_data=0xDEADBEEF_CAFEF00D, rd=5, Regwrite=1.
- Misaligned load from 0x1C with Regwrite=1 -> mem_wb_err=1, Regwrite=0, mem_data=0, no stall.
- Wrap-around (DEPTH=256): store 0x55 to 0x800 (word 0), then load 0x0 -> returns 0x55.
- Illegal request (Memread=Memwrite=1 at 0x20, data 0x1234): memory at 0x20 unchanged on a later load, err=1.
- Overflow: ADD result 0x8000_0000_0000_0000 with overflow=1, Regwrite=1, rd=3:
  - With MEM_OVERFLOW_TRAP_EN defined: Regwrite=0, trap=1.
  - Without it: Regwrite=1, trap=0, alu_result passed through.
